// File: rtl/tx_sched.sv
// Round-robin scheduler sharing one serial frame transmitter between N_REQ byte requesters.
// state | meaning:  IDLE | arbitrating;  WAIT | frame in flight, watchdog running;  GAP | enforced inter-frame idle.
module tx_sched #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 8,
  parameter int TIMEOUT    = 32,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          en_mask,
  output logic [N_REQ-1:0]          gnt,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [CNT_W-1:0]          frame_cnt,
  output logic                      timeout_err,
  input  logic                      clr_err
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   rr_ptr, win_idx;
  logic               win_found;
  logic [N_REQ-1:0]   eligible;
  logic [TMR_W-1:0]   timer;
  logic [GAP_W-1:0]   gap_cnt;
  logic               grant, done_hit, timeout_hit, gap_last;

  assign eligible = req & en_mask;

  // Scan from the slot after the last winner, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!win_found && eligible[(int'(rr_ptr) + k) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  assign grant       = (state == IDLE) && win_found;
  assign done_hit    = (state == WAIT) && tx_done;
  // A completion arriving on the watchdog's last cycle still counts as success.
  assign timeout_hit = (state == WAIT) && !tx_done && (timer == TMR_LAST);
  assign gap_last    = (gap_cnt == GAP_LAST);
  assign busy        = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_found) state_next = WAIT;
      WAIT:    if (done_hit || timeout_hit) state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      rr_ptr      <= PTR_W'(N_REQ - 1);
      timer       <= '0;
      gap_cnt     <= '0;
      frame_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      gnt      <= '0;
      tx_start <= 1'b0;
      if (grant) begin
        gnt      <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
        tx_start <= 1'b1;
        tx_data  <= req_data[win_idx*DATA_W +: DATA_W];
        rr_ptr   <= win_idx;
        timer    <= '0;
      end else if (state == WAIT && !done_hit && !timeout_hit) begin
        timer <= timer + 1'b1;
      end

      if (state == GAP && !gap_last) gap_cnt <= gap_cnt + 1'b1;
      else                           gap_cnt <= '0;

      if (done_hit) frame_cnt <= frame_cnt + 1'b1;

      if (timeout_hit)  timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_sched.sv
// Bench for tx_sched: directed scenarios plus random traffic, checked each cycle against a behavioural model.
module tb_tx_sched;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 32;
  localparam int GP = 2;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst, tx_start, tx_done, busy, timeout_err, clr_err;
  logic [N-1:0]    req, en_mask, gnt;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   tx_data;
  logic [CW-1:0]   frame_cnt;

  tx_sched #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TO), .GAP_CYCLES(GP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .en_mask(en_mask),
    .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .frame_cnt(frame_cnt), .timeout_err(timeout_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 frame in flight, 2 gap.
  int            m_phase, m_wait, m_gap, m_ptr, m_cnt;
  logic [N-1:0]  m_gnt;
  logic          m_start, m_err;
  logic [DW-1:0] m_data;

  task automatic model_step();
    logic         set_err;
    logic [N-1:0] elig;
    int           base, i;
    set_err = 1'b0;
    m_gnt   = '0;
    m_start = 1'b0;
    if (rst) begin
      m_phase = 0; m_wait = 0; m_gap = 0; m_ptr = N - 1; m_cnt = 0;
      m_data = '0; m_err = 1'b0;
      return;
    end
    case (m_phase)
      0: begin
        elig = req & en_mask;
        base = m_ptr;
        for (int k = 1; k <= N; k++) begin
          i = (base + k) % N;
          if (!m_start && elig[i]) begin
            m_gnt[i] = 1'b1;
            m_start  = 1'b1;
            m_data   = req_data[i*DW +: DW];
            m_ptr    = i;
            m_phase  = 1;
            m_wait   = 0;
          end
        end
      end
      1: begin
        if (tx_done) begin
          m_cnt   = (m_cnt + 1) % (1 << CW);
          m_phase = (GP > 0) ? 2 : 0;
          m_gap   = 0;
        end else if (m_wait == TO - 1) begin
          set_err = 1'b1;
          m_phase = (GP > 0) ? 2 : 0;
          m_gap   = 0;
        end else begin
          m_wait++;
        end
      end
      default: begin
        m_gap++;
        if (m_gap == GP) m_phase = 0;
      end
    endcase
    if (clr_err) m_err = 1'b0;
    if (set_err) m_err = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("gnt", gnt, m_gnt);
    check("tx_start", tx_start, m_start);
    check("tx_data", tx_data, m_data);
    check("busy", busy, m_phase != 0);
    check("frame_cnt", frame_cnt, m_cnt);
    check("timeout_err", timeout_err, m_err);
  endtask

  task automatic set_req(input int i, input logic v, input logic [DW-1:0] d);
    req[i] = v;
    req_data[i*DW +: DW] = d;
  endtask

  // Returns the index the DUT granted, or -1 if the budget ran out.
  task automatic wait_grant(input int budget, output int idx);
    idx = -1;
    for (int c = 0; c < budget; c++) begin
      cycle();
      if (m_start || gnt != 0) begin
        for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
        break;
      end
    end
    check("grant_seen", idx >= 0, 1'b1);
  endtask

  // d >= 0: tx_done pulsed d cycles after the tx_start cycle; d < 0: never.
  task automatic finish_frame(input int d, input int budget);
    if (d >= 0) begin
      repeat (d) cycle();
      tx_done = 1'b1;
      cycle();
      tx_done = 1'b0;
    end
    for (int c = 0; c < budget && m_phase != 0; c++) cycle();
    check("back_idle", busy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  int idx, cnt_before;
  int order[6];
  int exp_order[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst = 1'b1; req = '0; req_data = '0; en_mask = '1; tx_done = 1'b0; clr_err = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_cnt", frame_cnt, 0);

    // Single request, basic frame
    set_req(2, 1'b1, 8'hA5);
    wait_grant(1, idx);
    check("t1_idx", idx, 2);
    check("t1_data", tx_data, 8'hA5);
    set_req(2, 1'b0, 8'h00);
    finish_frame(12, 20);
    check("t1_cnt", frame_cnt, 1);

    // Round-robin with everyone requesting
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(8'h10 * i + 1));
    for (int f = 0; f < 6; f++) begin
      wait_grant(4, idx);
      order[f] = idx;
      if (idx >= 0) set_req(idx, 1'b1, 8'($urandom));
      finish_frame(3, 20);
    end
    for (int f = 0; f < 6; f++) check("t2_order", order[f], exp_order[f]);
    check("t2_cnt", frame_cnt, 6);
    req = '0;
    cycle();

    // Masking
    en_mask = 4'b1011;
    set_req(2, 1'b1, 8'h5A);
    repeat (20) cycle();
    check("t3_masked_busy", busy, 1'b0);
    en_mask = 4'b1111;
    wait_grant(1, idx);
    check("t3_idx", idx, 2);
    set_req(2, 1'b0, 8'h00);
    finish_frame(2, 20);

    // Timeout, then clear
    cnt_before = m_cnt;
    set_req(1, 1'b1, 8'hC3);
    wait_grant(4, idx);
    set_req(1, 1'b0, 8'h00);
    repeat (31) cycle();
    check("t4_err_early", timeout_err, 1'b0);
    cycle();
    check("t4_err", timeout_err, 1'b1);
    finish_frame(-1, 10);
    check("t4_cnt", frame_cnt, cnt_before);
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    check("t4_clr", timeout_err, 1'b0);

    // Completion on the watchdog's last cycle
    set_req(1, 1'b1, 8'h3C);
    wait_grant(4, idx);
    set_req(1, 1'b0, 8'h00);
    finish_frame(31, 10);
    check("t4_late_err", timeout_err, 1'b0);
    check("t4_late_cnt", frame_cnt, (cnt_before + 1) % 16);

    // Clear and new timeout together: set wins
    set_req(0, 1'b1, 8'h77);
    wait_grant(4, idx);
    set_req(0, 1'b0, 8'h00);
    repeat (31) cycle();
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    check("t4_set_wins", timeout_err, 1'b1);
    finish_frame(-1, 10);

    // Reset in the 5th WAIT cycle
    set_req(3, 1'b1, 8'hE1);
    wait_grant(4, idx);
    set_req(3, 1'b0, 8'h00);
    repeat (4) cycle();
    do_reset();
    check("t5_rst_start", tx_start, 1'b0);
    check("t5_rst_data", tx_data, 0);
    check("t5_rst_err", timeout_err, 1'b0);
    check("t5_rst_cnt", frame_cnt, 0);
    set_req(0, 1'b1, 8'h11);
    set_req(3, 1'b1, 8'h33);
    wait_grant(1, idx);
    check("t5_first_idx", idx, 0);
    req = '0;
    finish_frame(2, 20);

    // Counter wrap
    do_reset();
    for (int f = 0; f < 16; f++) begin
      set_req(f % N, 1'b1, 8'(f));
      wait_grant(4, idx);
      req = '0;
      finish_frame(1, 20);
      if (f == 14) check("wrap_15", frame_cnt, 15);
    end
    check("wrap_0", frame_cnt, 0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_gnt[i]) begin
          if ($urandom % 2 == 0) req[i] = 1'b0;
          else req_data[i*DW +: DW] = 8'($urandom);
        end else if (!req[i] && $urandom % 5 == 0) begin
          set_req(i, 1'b1, 8'($urandom));
        end
      end
      if ($urandom % 60 == 0) en_mask = N'($urandom);
      tx_done = ($urandom % 14 == 0);
      clr_err = ($urandom % 40 == 0);
      rst     = ($urandom % 500 == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
